multicycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit, 8-entry-register processor datapath. It owns the 3-bit PC and the instruction register, and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB. In each state it drives the per-state datapath enables (regWrite, memRead, memWrite, ALUsrc, regDst, memtoReg, ALUop). It replaces the single-cycle combinational control path, so register and memory writes occur only in their designated states.

---
 rtl/multicycle_sequencer_if.sv | 36 +++
 rtl/multicycle_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Bundle of the sequencer's instruction-side inputs and datapath control outputs.
// The slave modport is the sequencer's view; the master modport is the datapath/memory view.
interface multicycle_sequencer_if #(
    parameter int PC_W  = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic [15:0]      instr;
    logic             zero_flag;
    logic [PC_W-1:0]  pc;
    logic [15:0]      ir;
    logic             ir_load;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  start, instr, zero_flag,
        output pc, ir, ir_load, reg_write, mem_read, mem_write, alu_src,
               reg_dst, mem_to_reg, alu_op, state, busy, halted, instr_count
    );

    modport master (
        output start, instr, zero_flag,
        input  pc, ir, ir_load, reg_write, mem_read, mem_write, alu_src,
               reg_dst, mem_to_reg, alu_op, state, busy, halted, instr_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: owns pc and the instruction register and steps
// each instruction through FETCH/DECODE/EXECUTE/MEM/WB, driving the datapath
// enables as Moore outputs of (state, ir).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; pc=0 after reset
// FETCH   | ir_load high; ir captures instr[pc] at the end of the cycle
// DECODE  | no enables; halt branches to HALT, everything else to EXECUTE
// EXECUTE | ALU operands/op selected; beq samples zero_flag; beq/j/nop retire
// MEM     | lw reads (continues to WB), sw writes and retires
// WB      | single reg_write cycle, then retire
// HALT    | parked until reset, all enables low
//
// The interface instance must be built with the same PC_W/CNT_W as this module.
module multicycle_sequencer #(
    parameter int PC_W  = 3,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [2:0]       opcode;
    logic [PC_W-1:0]  offset;
    logic [PC_W-1:0]  pc_inc;

    assign opcode = ir_q[15:13];
    // Branch/jump target field; with PC_W=3 an offset of 7 acts as -1.
    assign offset = PC_W'(ir_q[2:0]);
    assign pc_inc = pc_q + PC_W'(1);

    // State, pc, instruction register and retire counter; reset abandons any
    // instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, instruction capture and retire (pc update + count).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = bus.instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (opcode)
                    OP_LW, OP_SW:  state_d = S_MEM;
                    OP_R, OP_ADDI: state_d = S_WB;
                    default:       retire  = 1'b1;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LW) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
            case (opcode)
                // beq only ever retires from EXECUTE, where zero_flag is valid.
                OP_BEQ:  pc_d = bus.zero_flag ? (pc_inc + offset) : pc_inc;
                OP_J:    pc_d = offset;
                default: pc_d = pc_inc;
            endcase
        end
    end

    // Moore enables decoded from the registered state and ir only.
    always_comb begin
        bus.ir_load    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.ir_load = 1'b1;
            end
            S_EXECUTE, S_MEM, S_WB: begin
                // ALU controls stay at their EXECUTE values through MEM and WB.
                case (opcode)
                    OP_R: begin
                        bus.alu_op  = 2'b10;
                        bus.alu_src = 1'b0;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        bus.alu_op  = 2'b00;
                        bus.alu_src = 1'b1;
                    end
                    OP_BEQ: begin
                        bus.alu_op  = 2'b01;
                        bus.alu_src = 1'b0;
                    end
                    default: begin
                        bus.alu_op  = 2'b00;
                        bus.alu_src = 1'b0;
                    end
                endcase
                if (state_q == S_MEM) begin
                    bus.mem_read  = (opcode == OP_LW);
                    bus.mem_write = (opcode == OP_SW);
                end
                if (state_q == S_WB) begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (opcode == OP_R);
                    bus.mem_to_reg = (opcode == OP_LW);
                    bus.mem_read   = (opcode == OP_LW);
                end
            end
            default: begin
                bus.ir_load = 1'b0;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.ir          = ir_q;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: single-instruction vector table, directed
// corner sequences, and a randomized run against an instruction-level model.
module tb_multicycle_sequencer;
    localparam int PC_W  = 3;
    localparam int CNT_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXE = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    multicycle_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [15:0] imem [8];
    assign bus.instr = imem[bus.pc];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] instr;
        int          addr;
        logic        zf;
        int          exp_pc;
        int          exp_cyc;
        int          exp_rw;
        int          exp_mr;
        int          exp_mw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a sample point; the pulse ends well before the next edge.
    task automatic do_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    function automatic logic [8:0] dut_en();
        return {bus.ir_load, bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src,
                bus.reg_dst, bus.mem_to_reg, bus.alu_op};
    endfunction

    // Runs one instruction starting from a FETCH sample; stops at the next FETCH,
    // HALT or IDLE, or after a bounded number of cycles.
    task automatic run_instr(output int cyc, output int rw, output int mr, output int mw);
        cyc = 0; rw = 0; mr = 0; mw = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.state == ST_HALT || bus.state == ST_IDLE) break;
            if (bus.state == ST_FETCH && cyc > 0) break;
            cyc++;
            rw += int'(bus.reg_write);
            mr += int'(bus.mem_read);
            mw += int'(bus.mem_write);
            tick();
        end
    endtask

    // Instruction-level reference: cycles per opcode and what each cycle does.
    function automatic int cpi(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b011: return 4;
            3'b010:                 return 5;
            3'b111:                 return 2;
            default:                return 3;
        endcase
    endfunction

    function automatic logic [2:0] phase(input logic [2:0] op, input int idx);
        case (idx)
            0:       return ST_FETCH;
            1:       return ST_DEC;
            2:       return ST_EXE;
            3:       return (op == 3'b010 || op == 3'b011) ? ST_MEM : ST_WB;
            default: return ST_WB;
        endcase
    endfunction

    // {ir_load, reg_write, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, alu_op}
    function automatic logic [8:0] exp_en(input logic [2:0] ph, input logic [2:0] op);
        logic [8:0] e;
        e = '0;
        if (ph == ST_FETCH) e[8] = 1'b1;
        if (ph == ST_EXE || ph == ST_MEM || ph == ST_WB) begin
            if (op == 3'b000) e[1:0] = 2'b10;
            if (op == 3'b001 || op == 3'b010 || op == 3'b011) e[4] = 1'b1;
            if (op == 3'b100) e[1:0] = 2'b01;
        end
        if (ph == ST_MEM) begin
            if (op == 3'b010) e[6] = 1'b1;
            if (op == 3'b011) e[5] = 1'b1;
        end
        if (ph == ST_WB) begin
            e[7] = 1'b1;
            if (op == 3'b000) e[3] = 1'b1;
            if (op == 3'b010) begin
                e[2] = 1'b1;
                e[6] = 1'b1;
            end
        end
        return e;
    endfunction

    initial begin
        vec_t        v [10];
        int          c, r, m, w;
        int          acc;
        logic [7:0]  rw_mask;
        int          m_mode, m_idx, halt_wait;
        logic [2:0]  m_pc, op, ph;
        logic [7:0]  m_cnt;
        logic [15:0] m_ir;
        logic        m_zf;

        bus.start     = 1'b0;
        bus.zero_flag = 1'b0;
        for (int k = 0; k < 8; k++) imem[k] = 16'hC000;
        #3;
        rst = 1'b0;
        #1;

        // Reset state
        chk("reset_state", 32'(bus.state), 32'(ST_IDLE));
        chk("reset_pc_ir_cnt", {bus.ir, 5'(bus.pc), bus.instr_count}, 32'h0);
        chk("reset_enables", {23'd0, dut_en()}, 32'h0);
        chk("reset_busy_halted", {30'd0, bus.busy, bus.halted}, 32'h0);

        // Idle with start low
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.state != ST_IDLE || bus.busy) acc++;
        end
        chk("idle_10_cycles", acc, 0);

        //             instr     addr zf pc  cyc rw mr mw
        v[0] = '{16'h0530, 0, 1'b0, 1, 4, 1, 0, 0};  // R-type
        v[1] = '{16'h2405, 1, 1'b0, 2, 4, 1, 0, 0};  // addi
        v[2] = '{16'h4483, 0, 1'b0, 1, 5, 1, 2, 0};  // lw
        v[3] = '{16'h6483, 1, 1'b0, 2, 4, 0, 0, 1};  // sw
        v[4] = '{16'h8002, 3, 1'b1, 6, 3, 0, 0, 0};  // beq taken +2
        v[5] = '{16'h8002, 3, 1'b0, 4, 3, 0, 0, 0};  // beq not taken
        v[6] = '{16'h8007, 0, 1'b1, 0, 3, 0, 0, 0};  // beq offset -1 at pc 0
        v[7] = '{16'hA005, 2, 1'b0, 5, 3, 0, 0, 0};  // j 5
        v[8] = '{16'hC000, 7, 1'b0, 0, 3, 0, 0, 0};  // nop wraps pc
        v[9] = '{16'hE000, 2, 1'b0, 2, 2, 0, 0, 0};  // halt

        for (int i = 0; i < 10; i++) begin
            do_reset();
            for (int k = 0; k < 8; k++) imem[k] = 16'hC000;
            if (v[i].addr != 0) imem[0] = {13'b101_0000000000, 3'(v[i].addr)};
            imem[v[i].addr] = v[i].instr;
            bus.zero_flag = v[i].zf;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            if (v[i].addr != 0) run_instr(c, r, m, w);
            run_instr(c, r, m, w);
            chk($sformatf("vec%0d_cycles", i), c, v[i].exp_cyc);
            chk($sformatf("vec%0d_rw_mr_mw", i), r * 100 + m * 10 + w,
                v[i].exp_rw * 100 + v[i].exp_mr * 10 + v[i].exp_mw);
            chk($sformatf("vec%0d_pc", i), 32'(bus.pc), v[i].exp_pc);
            chk($sformatf("vec%0d_count", i), 32'(bus.instr_count),
                (v[i].addr != 0 ? 1 : 0) + (v[i].instr[15:13] == 3'b111 ? 0 : 1));
        end

        // Still parked in HALT from the last vector: start pulses are ignored.
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            bus.start = (k % 2 == 0);
            tick();
            if (bus.state != ST_HALT || !bus.halted || bus.busy || bus.pc != 3'd2 ||
                bus.instr_count != 8'd1 || dut_en() != 9'd0) acc++;
        end
        bus.start = 1'b0;
        chk("halt_ignores_start", acc, 0);
        do_reset();
        chk("halt_rst_to_idle", {bus.halted, bus.state}, {1'b0, ST_IDLE});

        // Reset in the middle of an R-type EXECUTE
        for (int k = 0; k < 8; k++) imem[k] = 16'h0530;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("midexe_state", 32'(bus.state), 32'(ST_EXE));
        rst = 1'b1;
        #1;
        chk("midexe_async_reset", {bus.state, 5'(bus.pc), bus.instr_count}, 32'h0);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) rst = 1'b0;
            tick();
            acc += int'(bus.reg_write) + (bus.state != ST_IDLE ? 10 : 0);
        end
        chk("midexe_no_write_after_rst", acc, 0);

        // R-type then addi: reg_write exactly in cycles 4 and 8 after start
        do_reset();
        for (int k = 0; k < 8; k++) imem[k] = 16'hC000;
        imem[0] = 16'h0530;
        imem[1] = 16'h2405;
        bus.start = 1'b1;
        rw_mask = '0;
        for (int cy = 1; cy <= 8; cy++) begin
            tick();
            bus.start = 1'b0;
            rw_mask[cy-1] = bus.reg_write;
            if (cy == 4) chk("r_wb_ctrl", {bus.reg_dst, bus.mem_to_reg, bus.alu_op}, 4'b1010);
            if (cy == 8) chk("addi_wb_ctrl", {bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.alu_op},
                             5'b00100);
        end
        chk("r_addi_rw_cycles", rw_mask, 8'b1000_1000);
        tick();
        chk("r_addi_pc_count", {bus.pc, bus.instr_count}, {3'd2, 8'd2});

        // Randomized run against the instruction-level model
        do_reset();
        m_mode = 0; m_idx = 0; m_pc = '0; m_cnt = '0; m_ir = '0; m_zf = 1'b0; halt_wait = 0;
        for (int k = 0; k < 8; k++) imem[k] = 16'($urandom);
        for (int it = 0; it < 3000; it++) begin
            if ((m_mode == 2 && halt_wait >= 4) || $urandom_range(0, 299) == 0) begin
                do_reset();
                m_mode = 0; m_idx = 0; m_pc = '0; m_cnt = '0; m_ir = '0;
                for (int k = 0; k < 8; k++) imem[k] = 16'($urandom);
            end
            bus.start     = ($urandom_range(0, 2) == 0);
            bus.zero_flag = 1'($urandom_range(0, 1));

            case (m_mode)
                0: if (bus.start) begin
                    m_mode = 1;
                    m_idx  = 0;
                end
                1: begin
                    op = imem[m_pc][15:13];
                    ph = phase(op, m_idx);
                    if (ph == ST_FETCH) m_ir = imem[m_pc];
                    if (ph == ST_EXE) m_zf = bus.zero_flag;
                    if (op == 3'b111 && m_idx == 1) begin
                        m_mode = 2;
                        halt_wait = 0;
                    end else if (m_idx == cpi(op) - 1) begin
                        if (op == 3'b100 && m_zf) m_pc = m_pc + 3'd1 + m_ir[2:0];
                        else if (op == 3'b101)    m_pc = m_ir[2:0];
                        else                      m_pc = m_pc + 3'd1;
                        m_cnt = m_cnt + 8'd1;
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
                default: halt_wait++;
            endcase

            tick();

            if (m_mode == 1) ph = phase(imem[m_pc][15:13], m_idx);
            else if (m_mode == 2) ph = ST_HALT;
            else ph = ST_IDLE;
            chk("rand_state", 32'(bus.state), 32'(ph));
            chk("rand_pc", 32'(bus.pc), 32'(m_pc));
            chk("rand_ir", 32'(bus.ir), 32'(m_ir));
            chk("rand_count", 32'(bus.instr_count), 32'(m_cnt));
            chk("rand_enables", 32'(dut_en()), 32'(m_mode == 1 ? exp_en(ph, m_ir[15:13]) : 9'd0));
            chk("rand_busy_halted", {bus.busy, bus.halted}, {m_mode == 1, m_mode == 2});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
